experiment_cmd_responder: RTL and testbench

//  Device-side responder for the EXPERIMENT_CMDS byte protocol. Decodes command bytes from the host link,

---
 rtl/experiment_cmd_responder_pkg.sv | 34 +++
 rtl/experiment_cmd_responder_if.sv | 21 ++
 rtl/experiment_cmd_responder_resp_serializer.sv | 37 +++
 rtl/experiment_cmd_responder.sv | 189 ++++++++++++++++++
 tb/tb_experiment_cmd_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/experiment_cmd_responder_pkg.sv
// Opcodes, operand indices, response codes and FSM states for the
// EXPERIMENT_CMDS responder.
package experiment_cmd_responder_pkg;

   localparam logic [7:0] CMD_WRITE_OP            = 8'h00;
   localparam logic [7:0] CMD_READ_RESULT         = 8'h02;
   localparam logic [7:0] CMD_TRIGGER_MEASUREMENT = 8'h03;
   localparam logic [7:0] CMD_READ_READY          = 8'h04;
   localparam logic [7:0] CMD_READ_AGING_SENSOR   = 8'h05;
   localparam logic [7:0] CMD_MODULE_SELECT       = 8'h06;

   localparam logic [7:0] OPERAND_IDX_X = 8'h00;
   localparam logic [7:0] OPERAND_IDX_Y = 8'h01;

   localparam logic [7:0] RESP_ERR_CMD     = 8'hEE;
   localparam logic [7:0] RESP_ERR_ARG     = 8'hE1;
   localparam logic [7:0] RESP_ERR_TIMEOUT = 8'hE2;

   typedef enum logic [1:0] {
      CMD_IDLE,
      CMD_ARGS,
      CMD_EXEC,
      CMD_RESP
   } cmd_resp_state_t;

   function automatic logic [1:0] cmd_arg_len(logic [7:0] op);
      logic [1:0] n;
      n = 2'd0;
      if (op == CMD_WRITE_OP)      n = 2'd3;
      if (op == CMD_MODULE_SELECT) n = 2'd1;
      return n;
   endfunction

endpackage

// File: rtl/experiment_cmd_responder_if.sv
// Host byte link: command bytes in (rx), response bytes out (tx).
interface experiment_cmd_responder_if;

   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output rx_data, rx_valid, tx_ready,
      input  rx_ready, tx_data, tx_valid
   );

   modport slave (
      input  rx_data, rx_valid, tx_ready,
      output rx_ready, tx_data, tx_valid
   );

endinterface

// File: rtl/experiment_cmd_responder_resp_serializer.sv
// Response shifter: loads up to 4 left-aligned bytes plus a count and
// emits them MSB first over a valid/ready handshake.
module experiment_cmd_responder_resp_serializer (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [2:0]  load_cnt,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        last
);

   logic [31:0] sh;
   logic [2:0]  cnt;
   logic        fire;

   assign tx_valid = (cnt != 3'd0);
   assign tx_data  = sh[31:24];
   assign fire     = tx_valid & tx_ready;
   assign last     = fire & (cnt == 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         sh  <= '0;
         cnt <= '0;
      end else if (load) begin
         sh  <= load_data;
         cnt <= load_cnt;
      end else if (fire) begin
         sh  <= {sh[23:0], 8'h00};
         cnt <= cnt - 3'd1;
      end
   end

endmodule

// File: rtl/experiment_cmd_responder.sv
// EXPERIMENT_CMDS device-side responder: decodes host bytes, drives FRAME_IN.
// Optional inter-byte timeout enabled by defining CMD_TIMEOUT_EN.
module experiment_cmd_responder
   import experiment_cmd_responder_pkg::*;
#(
   parameter int NUM_MODULES    = 4,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int SELW = (NUM_MODULES > 1) ? $clog2(NUM_MODULES) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   experiment_cmd_responder_if.slave link,
   output logic [15:0]               xin,
   output logic [15:0]               yin,
   output logic                      trigger_measurement,
   output logic [SELW-1:0]           module_sel,
   input  logic [19:0]               rout,
   input  logic [31:0]               aging_value,
   input  logic                      meas_ready
);

   cmd_resp_state_t state;
   logic [7:0]  op;
   logic [23:0] args;
   logic [1:0]  argn;
   logic        rdy;
   logic        rx_fire;
   logic        arg_last;
   logic [7:0]  idx;
   logic        exec_err;
   logic        tmo_hit;
   logic        ld;
   logic [31:0] ld_data;
   logic [2:0]  ld_cnt;
   logic        ser_last;

   assign link.rx_ready = rdy;
   assign rx_fire       = link.rx_valid & rdy;
   assign arg_last      = (argn == cmd_arg_len(op) - 2'd1);
   assign idx           = (op == CMD_WRITE_OP) ? args[23:16] : args[7:0];

   always_comb begin
      exec_err = 1'b0;
      if (op == CMD_WRITE_OP)
         exec_err = (idx != OPERAND_IDX_X) && (idx != OPERAND_IDX_Y);
      if (op == CMD_MODULE_SELECT)
         exec_err = ({24'd0, idx} >= 32'(NUM_MODULES));
   end

`ifdef CMD_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tmo_cnt;

   assign tmo_hit = (state == CMD_ARGS) && !rx_fire &&
                    (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst)
         tmo_cnt <= '0;
      else if (state == CMD_ARGS && !rx_fire)
         tmo_cnt <= tmo_cnt + 1'b1;
      else
         tmo_cnt <= '0;
   end
`else
   assign tmo_hit = 1'b0;
`endif

   // Read values are captured here, on the opcode-accept cycle.
   always_comb begin
      ld      = 1'b0;
      ld_data = '0;
      ld_cnt  = '0;
      if (state == CMD_IDLE && rx_fire) begin
         unique case (link.rx_data)
            CMD_READ_RESULT: begin
               ld      = 1'b1;
               ld_data = {4'h0, rout, 8'h00};
               ld_cnt  = 3'd3;
            end
            CMD_READ_READY: begin
               ld      = 1'b1;
               ld_data = {7'd0, meas_ready, 24'd0};
               ld_cnt  = 3'd1;
            end
            CMD_READ_AGING_SENSOR: begin
               ld      = 1'b1;
               ld_data = aging_value;
               ld_cnt  = 3'd4;
            end
            CMD_WRITE_OP, CMD_TRIGGER_MEASUREMENT,
            CMD_MODULE_SELECT: ld = 1'b0;
            default: begin
               ld      = 1'b1;
               ld_data = {RESP_ERR_CMD, 24'd0};
               ld_cnt  = 3'd1;
            end
         endcase
      end else if (state == CMD_EXEC && exec_err) begin
         ld      = 1'b1;
         ld_data = {RESP_ERR_ARG, 24'd0};
         ld_cnt  = 3'd1;
      end else if (tmo_hit) begin
         ld      = 1'b1;
         ld_data = {RESP_ERR_TIMEOUT, 24'd0};
         ld_cnt  = 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= CMD_IDLE;
         op                  <= '0;
         args                <= '0;
         argn                <= '0;
         rdy                 <= 1'b0;
         xin                 <= '0;
         yin                 <= '0;
         module_sel          <= '0;
         trigger_measurement <= 1'b0;
      end else begin
         trigger_measurement <= 1'b0;
         unique case (state)
            CMD_IDLE: begin
               rdy <= 1'b1;
               if (rx_fire) begin
                  op   <= link.rx_data;
                  argn <= '0;
                  if (link.rx_data == CMD_TRIGGER_MEASUREMENT) begin
                     trigger_measurement <= 1'b1;
                  end else if (cmd_arg_len(link.rx_data) != 2'd0) begin
                     state <= CMD_ARGS;
                  end else begin
                     state <= CMD_RESP;
                     rdy   <= 1'b0;
                  end
               end
            end
            CMD_ARGS: begin
               if (rx_fire) begin
                  args <= {args[15:0], link.rx_data};
                  argn <= argn + 2'd1;
                  if (arg_last) begin
                     state <= CMD_EXEC;
                     rdy   <= 1'b0;
                  end
               end else if (tmo_hit) begin
                  state <= CMD_RESP;
                  rdy   <= 1'b0;
               end
            end
            CMD_EXEC: begin
               if (exec_err) begin
                  state <= CMD_RESP;
               end else begin
                  if (op == CMD_WRITE_OP && idx == OPERAND_IDX_X)
                     xin <= args[15:0];
                  if (op == CMD_WRITE_OP && idx == OPERAND_IDX_Y)
                     yin <= args[15:0];
                  if (op == CMD_MODULE_SELECT)
                     module_sel <= idx[SELW-1:0];
                  state <= CMD_IDLE;
                  rdy   <= 1'b1;
               end
            end
            CMD_RESP: begin
               if (ser_last) begin
                  state <= CMD_IDLE;
                  rdy   <= 1'b1;
               end
            end
            default: state <= CMD_IDLE;
         endcase
      end
   end

   experiment_cmd_responder_resp_serializer u_ser (
      .clk       (clk),
      .rst       (rst),
      .load      (ld),
      .load_data (ld_data),
      .load_cnt  (ld_cnt),
      .tx_data   (link.tx_data),
      .tx_valid  (link.tx_valid),
      .tx_ready  (link.tx_ready),
      .last      (ser_last)
   );

endmodule

// File: tb/tb_experiment_cmd_responder.sv
// Directed bench for experiment_cmd_responder with hand-computed vectors.
// Define CMD_TIMEOUT_EN for both RTL and bench to exercise the timeout.
module tb_experiment_cmd_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] xin, yin;
   logic        trig;
   logic [1:0]  module_sel;
   logic [19:0] rout;
   logic [31:0] aging_value;
   logic        meas_ready;

   int vectors = 0;
   int miscompares = 0;

   experiment_cmd_responder_if link ();

   experiment_cmd_responder dut (
      .clk                 (clk),
      .rst                 (rst),
      .link                (link.slave),
      .xin                 (xin),
      .yin                 (yin),
      .trigger_measurement (trig),
      .module_sel          (module_sel),
      .rout                (rout),
      .aging_value         (aging_value),
      .meas_ready          (meas_ready)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      link.rx_data  = b;
      link.rx_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         if (link.rx_ready) ok = 1'b1;
         tick();
      end
      link.rx_valid = 1'b0;
      if (!ok) chk("rx_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic recv(input string tag, input logic [7:0] exp,
                       input int hold);
      bit ok;
      bit stable;
      logic [7:0] d0;
      ok = 1'b0;
      link.tx_ready = 1'b0;
      for (int i = 0; i < 2000 && !ok; i++) begin
         if (link.tx_valid) ok = 1'b1;
         else tick();
      end
      if (!ok) begin
         chk({tag, "_no_tx"}, 32'd0, 32'd1);
      end else begin
         d0 = link.tx_data;
         stable = 1'b1;
         for (int i = 0; i < hold; i++) begin
            tick();
            if (!link.tx_valid || link.tx_data !== d0) stable = 1'b0;
         end
         if (hold > 0) chk({tag, "_stable"}, 32'(stable), 32'd1);
         chk(tag, 32'(link.tx_data), 32'(exp));
         link.tx_ready = 1'b1;
         tick();
         link.tx_ready = 1'b0;
      end
   endtask

   initial begin
      rst           = 1'b1;
      link.rx_data  = 8'h00;
      link.rx_valid = 1'b0;
      link.tx_ready = 1'b0;
      rout          = '0;
      aging_value   = '0;
      meas_ready    = 1'b0;
      tick();
      tick();
      chk("rst_rx_ready", 32'(link.rx_ready), 32'd0);
      chk("rst_tx_valid", 32'(link.tx_valid), 32'd0);
      chk("rst_xin", 32'(xin), 32'd0);
      chk("rst_yin", 32'(yin), 32'd0);
      chk("rst_sel", 32'(module_sel), 32'd0);
      chk("rst_trig", 32'(trig), 32'd0);
      rst = 1'b0;
      tick();
      chk("idle_rx_ready", 32'(link.rx_ready), 32'd1);

      // operand writes
      send(8'h00); send(8'h00); send(8'h12); send(8'h34);
      chk("xin_before_exec", 32'(xin), 32'd0);
      tick();
      chk("xin_write", 32'(xin), 32'h1234);
      chk("yin_after_x", 32'(yin), 32'd0);
      chk("write_no_tx", 32'(link.tx_valid), 32'd0);
      send(8'h00); send(8'h01); send(8'hAB); send(8'hCD);
      tick();
      chk("yin_write", 32'(yin), 32'hABCD);
      chk("xin_kept", 32'(xin), 32'h1234);
      send(8'h00); send(8'h05); send(8'h11); send(8'h22);
      recv("bad_idx_err", 8'hE1, 0);
      chk("bad_idx_xin", 32'(xin), 32'h1234);
      chk("bad_idx_yin", 32'(yin), 32'hABCD);

      // result read with snapshot
      rout = 20'hF1234;
      send(8'h02);
      chk("result_latency", 32'(link.tx_valid), 32'd1);
      chk("resp_rx_blocked", 32'(link.rx_ready), 32'd0);
      rout = 20'h00055;
      recv("result_b0", 8'h0F, 0);
      recv("result_b1", 8'h12, 0);
      recv("result_b2", 8'h34, 0);
      chk("result_done_idle", 32'(link.rx_ready), 32'd1);
      chk("result_done_tx", 32'(link.tx_valid), 32'd0);

      // aging read under backpressure
      aging_value = 32'hDEADBEEF;
      send(8'h05);
      recv("aging_b0", 8'hDE, 10);
      recv("aging_b1", 8'hAD, 10);
      recv("aging_b2", 8'hBE, 10);
      recv("aging_b3", 8'hEF, 10);
      tick();
      chk("aging_no_extra", 32'(link.tx_valid), 32'd0);

      // trigger pulse
      send(8'h03);
      chk("trig_high", 32'(trig), 32'd1);
      chk("trig_no_tx", 32'(link.tx_valid), 32'd0);
      tick();
      chk("trig_low", 32'(trig), 32'd0);
      chk("trig_no_tx2", 32'(link.tx_valid), 32'd0);

      meas_ready = 1'b1;
      send(8'h04);
      recv("ready_1", 8'h01, 0);
      meas_ready = 1'b0;
      send(8'h04);
      recv("ready_0", 8'h00, 0);

      // module select incl. boundaries
      send(8'h06); send(8'h07);
      recv("sel_err7", 8'hE1, 0);
      chk("sel_kept", 32'(module_sel), 32'd0);
      send(8'h06); send(8'h02);
      tick();
      chk("sel_2", 32'(module_sel), 32'd2);
      send(8'h06); send(8'h03);
      tick();
      chk("sel_3", 32'(module_sel), 32'd3);
      send(8'h06); send(8'h04);
      recv("sel_err4", 8'hE1, 0);
      chk("sel_kept3", 32'(module_sel), 32'd3);

      // unknown opcodes
      send(8'h09);
      recv("unk_09", 8'hEE, 0);
      send(8'h01);
      recv("unk_01", 8'hEE, 0);
      send(8'hFF);
      recv("unk_ff", 8'hEE, 0);

      // reset mid-command: trailing byte must decode as a fresh opcode
      send(8'h00); send(8'h00); send(8'h12);
      rst = 1'b1;
      tick();
      chk("midcmd_rx_ready", 32'(link.rx_ready), 32'd0);
      chk("midcmd_xin", 32'(xin), 32'd0);
      rst = 1'b0;
      tick();
      send(8'h34);
      recv("midcmd_fresh", 8'hEE, 0);
      chk("midcmd_xin2", 32'(xin), 32'd0);

      // reset mid-response
      send(8'h05);
      recv("midresp_b0", 8'hDE, 0);
      chk("midresp_pending", 32'(link.tx_valid), 32'd1);
      rst = 1'b1;
      tick();
      chk("midresp_tx_drop", 32'(link.tx_valid), 32'd0);
      rst = 1'b0;
      tick();
      chk("midresp_idle", 32'(link.rx_ready), 32'd1);

`ifdef CMD_TIMEOUT_EN
      send(8'h06);
      recv("timeout_err", 8'hE2, 0);
      chk("timeout_sel", 32'(module_sel), 32'd0);
      chk("timeout_idle", 32'(link.rx_ready), 32'd1);
`else
      send(8'h06);
      repeat (1100) tick();
      chk("no_timeout_tx", 32'(link.tx_valid), 32'd0);
      chk("no_timeout_wait", 32'(link.rx_ready), 32'd1);
      send(8'h01);
      tick();
      chk("late_arg_sel", 32'(module_sel), 32'd1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
